// File: rtl/orv64_int_deleg_arb_pkg.sv
// ----------------------------------------------------------------------------
// orv64_int_deleg_arb_pkg
// Shared types and constants for the interrupt arbiter / delegation unit:
//   orv64_prv_t           privilege encoding (U=0, S=1, M=3)
//   orv64_int_arb_state_e arbiter FSM states
//   ORV64_INT_PRIO_ORDER  fixed priority of the standard causes 0..11
//   orv64_int_reserved()  true for the standard causes that never fire
// ----------------------------------------------------------------------------
package orv64_int_deleg_arb_pkg;

    typedef enum logic [1:0] {
        PRV_U = 2'b00,
        PRV_S = 2'b01,
        PRV_M = 2'b11
    } orv64_prv_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        COOL = 2'b10
    } orv64_int_arb_state_e;

    // Standard causes ordered highest priority first. Causes 2, 6 and 10 are
    // absent because they can never be eligible.
    localparam int unsigned ORV64_INT_PRIO_N = 9;
    localparam int unsigned ORV64_INT_PRIO_ORDER [ORV64_INT_PRIO_N] =
        '{11, 3, 7, 9, 1, 5, 8, 0, 4};

    // Index of the first platform/custom cause; these rank below all standard
    // causes, lower index first.
    localparam int unsigned ORV64_INT_CUSTOM_BASE = 12;

    function automatic logic orv64_int_reserved(input int unsigned idx);
        return (idx == 2) || (idx == 6) || (idx == 10);
    endfunction

endpackage

// File: rtl/orv64_int_deleg_arb_if.sv
// ----------------------------------------------------------------------------
// orv64_int_deleg_arb_if
// Valid/ready request channel from the interrupt arbiter to the trap logic.
//   int_valid   request present (master -> slave)
//   int_ready   trap logic takes the request (slave -> master)
//   int_cause   winning cause index, stable while int_valid is high
//   int_target  privilege the trap is taken into
// Modports: master (arbiter side), slave (trap logic side).
// ----------------------------------------------------------------------------
interface orv64_int_deleg_arb_if
    import orv64_int_deleg_arb_pkg::*;
#(
    parameter int CAUSE_W = 4
) ();

    logic               int_valid;
    logic               int_ready;
    logic [CAUSE_W-1:0] int_cause;
    orv64_prv_t         int_target;

    modport master (
        output int_valid,
        output int_cause,
        output int_target,
        input  int_ready
    );

    modport slave (
        input  int_valid,
        input  int_cause,
        input  int_target,
        output int_ready
    );

endinterface

// File: rtl/orv64_int_deleg_arb_prio_sel.sv
// ----------------------------------------------------------------------------
// orv64_int_prio_sel
// Combinational fixed-priority picker over the eligible-interrupt vector.
//   elig   per-cause eligibility (reserved causes are expected to be 0)
//   found  at least one cause is eligible
//   idx    winning cause index (0 when nothing is eligible)
// Order: 11,3,7,9,1,5,8,0,4, then causes 12..N_INT-1 ascending.
// ----------------------------------------------------------------------------
module orv64_int_prio_sel
    import orv64_int_deleg_arb_pkg::*;
#(
    parameter  int N_INT   = 16,
    localparam int CAUSE_W = $clog2(N_INT)
) (
    input  logic [N_INT-1:0]   elig,
    output logic               found,
    output logic [CAUSE_W-1:0] idx
);

    // Reserved causes are masked upstream and never take part in the choice.
    logic unused_reserved;
    assign unused_reserved = elig[2] | elig[6] | elig[10];

    // Scan from lowest to highest priority so the last hit wins.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int i = N_INT - 1; i >= int'(ORV64_INT_CUSTOM_BASE); i--) begin
            if (elig[i]) begin
                found = 1'b1;
                idx   = CAUSE_W'(i);
            end
        end
        for (int k = int'(ORV64_INT_PRIO_N) - 1; k >= 0; k--) begin
            if (elig[ORV64_INT_PRIO_ORDER[k]]) begin
                found = 1'b1;
                idx   = CAUSE_W'(ORV64_INT_PRIO_ORDER[k]);
            end
        end
    end

endmodule

// File: rtl/orv64_int_deleg_arb.sv
// ----------------------------------------------------------------------------
// orv64_int_deleg_arb
// Registered interrupt arbiter and delegation unit. Every cycle each pending
// and enabled cause is given a target privilege from mideleg/sideleg, checked
// against the current privilege and global enables, and the highest-priority
// eligible cause is offered to the trap logic over a valid/ready channel.
// After an accept the unit rests for COOLDOWN_CYC cycles so CSR side effects
// of the trap can settle before the next evaluation.
//
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   mip, mie          pending / enable bits
//   mideleg, sideleg  M->S and S->U delegation
//   prv               current privilege
//   mstatus_mie/sie/uie  global enables per privilege
//   int_kill          pipeline flush / debug halt: withdraws or blocks requests
//   int_bus           master side of the request channel
//   wfi_wake          registered OR of (mip & mie), ignores global enables
//
// Build option ORV64_INT_USER_DELEG_EN: when defined, sideleg and mstatus_uie
// allow delegation down to U mode; otherwise targets are only M or S.
// ----------------------------------------------------------------------------
module orv64_int_deleg_arb
    import orv64_int_deleg_arb_pkg::*;
#(
    parameter  int N_INT        = 16,
    parameter  int COOLDOWN_CYC = 2,
    localparam int CAUSE_W      = $clog2(N_INT)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_INT-1:0]       mip,
    input  logic [N_INT-1:0]       mie,
    input  logic [N_INT-1:0]       mideleg,
    input  logic [N_INT-1:0]       sideleg,
    input  orv64_prv_t             prv,
    input  logic                   mstatus_mie,
    input  logic                   mstatus_sie,
    input  logic                   mstatus_uie,
    input  logic                   int_kill,
    orv64_int_deleg_arb_if.master  int_bus,
    output logic                   wfi_wake
);

    localparam int CNT_W = (COOLDOWN_CYC > 1) ? $clog2(COOLDOWN_CYC) : 1;

    orv64_prv_t           tgt [N_INT];
    logic [N_INT-1:0]     elig;
    logic                 found;
    logic [CAUSE_W-1:0]   win;

    orv64_int_arb_state_e state_q, state_d;
    logic                 vld_p1, vld_d;
    logic [CAUSE_W-1:0]   cause_p1, cause_d;
    orv64_prv_t           target_p1, target_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 wfi_wake_p1;

    // Global enable that applies when a trap stays at the current privilege.
    function automatic logic gie_at(input orv64_prv_t p, input logic m_ie,
                                    input logic s_ie, input logic u_ie);
        case (p)
            PRV_M:   return m_ie;
            PRV_S:   return s_ie;
            PRV_U:   return u_ie;
            default: return 1'b0;
        endcase
    endfunction

`ifdef ORV64_INT_USER_DELEG_EN
    logic uie_eff;
    assign uie_eff = mstatus_uie;
`else
    logic uie_eff;
    logic unused_user_deleg;
    assign uie_eff           = 1'b0;
    assign unused_user_deleg = ^{sideleg, mstatus_uie};
`endif

    // Target privilege and eligibility per cause
    always_comb begin
        for (int i = 0; i < N_INT; i++) begin
            tgt[i] = PRV_M;
            if (mideleg[i]) begin
`ifdef ORV64_INT_USER_DELEG_EN
                tgt[i] = sideleg[i] ? PRV_U : PRV_S;
`else
                tgt[i] = PRV_S;
`endif
            end
        end
    end

    always_comb begin
        elig = '0;
        for (int i = 0; i < N_INT; i++) begin
            elig[i] = mip[i] & mie[i] & ~orv64_int_reserved(i) &
                      ((tgt[i] > prv) ||
                       ((tgt[i] == prv) &&
                        gie_at(prv, mstatus_mie, mstatus_sie, uie_eff)));
        end
    end

    orv64_int_prio_sel #(
        .N_INT (N_INT)
    ) u_prio_sel (
        .elig  (elig),
        .found (found),
        .idx   (win)
    );

    // Arbiter next state. A held request is never preempted; an accept takes
    // precedence over a simultaneous withdrawal.
    always_comb begin
        state_d  = state_q;
        vld_d    = vld_p1;
        cause_d  = cause_p1;
        target_d = target_p1;
        cnt_d    = cnt_q;
        case (state_q)
            IDLE: begin
                if (found && !int_kill) begin
                    state_d  = REQ;
                    vld_d    = 1'b1;
                    cause_d  = win;
                    target_d = tgt[win];
                end
            end
            REQ: begin
                if (int_bus.int_ready) begin
                    state_d = COOL;
                    vld_d   = 1'b0;
                    cnt_d   = CNT_W'(COOLDOWN_CYC - 1);
                end else if (!elig[cause_p1] || int_kill) begin
                    state_d = IDLE;
                    vld_d   = 1'b0;
                end
            end
            COOL: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                vld_d   = 1'b0;
            end
        endcase
    end

    // Stage p1: registered request and wake outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            vld_p1      <= 1'b0;
            cause_p1    <= '0;
            target_p1   <= PRV_M;
            cnt_q       <= '0;
            wfi_wake_p1 <= 1'b0;
        end else begin
            state_q     <= state_d;
            vld_p1      <= vld_d;
            cause_p1    <= cause_d;
            target_p1   <= target_d;
            cnt_q       <= cnt_d;
            wfi_wake_p1 <= |(mip & mie);
        end
    end

    assign int_bus.int_valid  = vld_p1;
    assign int_bus.int_cause  = cause_p1;
    assign int_bus.int_target = target_p1;
    assign wfi_wake           = wfi_wake_p1;

endmodule
